// File: rtl/enum_type.sv
// Shared state/command encoding between the tetris core, its input front end
// and the benches; CMD_PRIO is the issue order for pending player commands.
package enum_type;

  typedef enum logic [3:0] {
    NONE, INIT, WAIT, GEN, HOLD, ROTATE, ROTATE_REV, LEFT, RIGHT, DROP, DOWN,
    LOCK, CLEAR, END
  } state_type;

  localparam int NUM_CMD = 8;

  // Pending-flag index, highest priority first
  localparam int F_HOLD       = 0;
  localparam int F_ROTATE     = 1;
  localparam int F_ROTATE_REV = 2;
  localparam int F_LEFT       = 3;
  localparam int F_RIGHT      = 4;
  localparam int F_DROP       = 5;
  localparam int F_DOWN_USER  = 6;
  localparam int F_DOWN_GRAV  = 7;

  localparam logic [NUM_CMD-1:0] DOWN_MASK = 8'b1100_0000;

  localparam state_type CMD_PRIO [NUM_CMD] =
    '{HOLD, ROTATE, ROTATE_REV, LEFT, RIGHT, DROP, DOWN, DOWN};

  function automatic logic is_idle(state_type s);
    return (s == INIT) || (s == END);
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Held-key auto-repeat: first tick DAS ms after the press (ARR if DAS is 0),
// then one tick every ARR ms while the key stays held.
module key_repeat #(
  parameter int unsigned DAS = 170,
  parameter int unsigned ARR = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic held,
  input  logic ms_tick,
  output logic tick
);

  localparam int unsigned FIRST = (DAS == 0) ? ARR : DAS;

  logic        armed;
  logic        rep;
  logic [31:0] cnt;
  logic [31:0] lim;

  assign lim  = rep ? ARR : FIRST;
  assign tick = held && armed && ms_tick && ((cnt + 32'd1) == lim);

  // The press cycle only arms; counting starts on the following ms tick
  always_ff @(posedge clk) begin
    if (reset || !held) begin
      armed <= 1'b0;
      rep   <= 1'b0;
      cnt   <= '0;
    end else if (!armed) begin
      armed <= 1'b1;
      cnt   <= '0;
    end else if (ms_tick) begin
      if (tick) begin
        cnt <= '0;
        rep <= 1'b1;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Button/gravity/start front end producing one-cycle commands for the tetris
// core, plus score-derived level. Define TETRIS_CTRL_DAS_EN for auto-repeat.
module tetris_input_ctrl
  import enum_type::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned DAS_MS        = 170,
  parameter int unsigned ARR_MS        = 50,
  parameter int unsigned GRAV_BASE_MS  = 1000,
  parameter int unsigned GRAV_STEP_MS  = 60,
  parameter int unsigned GRAV_MIN_MS   = 100,
  parameter int unsigned PTS_PER_LEVEL = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_rotate_rev,
  input  logic       btn_down,
  input  logic       btn_drop,
  input  logic       btn_hold,
  input  logic       btn_start,
  input  state_type  game_state,
  input  logic       score_inc,
  output state_type  ctrl,
  output logic [3:0] level
);

  localparam int unsigned PRESCALE = (CLK_HZ < 1000) ? 1 : CLK_HZ / 1000;

  logic                  idle, in_gen, in_wait;
  logic [31:0]           pre_cnt;
  logic                  ms_tick;
  logic [7:0]            btn, btn_prev, press;
  logic                  armed;
  logic                  rpt_l, rpt_r, rpt_d;
  logic [NUM_CMD-1:0]    pend, pend_nxt, set_m, clr_m;
  logic [2:0]            top_idx;
  logic                  issue;
  state_type             ctrl_nxt;
  int                    grav_raw;
  logic [31:0]           grav_period, grav_cnt;
  logic                  grav_hit;
  logic [15:0]           points;
  logic [31:0]           lvl_div;

  assign idle    = is_idle(game_state);
  assign in_gen  = (game_state == GEN);
  assign in_wait = (game_state == WAIT);

  assign ms_tick = (pre_cnt == PRESCALE - 1);

  always_ff @(posedge clk) begin
    if (reset || ms_tick) pre_cnt <= '0;
    else                  pre_cnt <= pre_cnt + 32'd1;
  end

  // Bit order follows the pending-flag indices; start rides on bit 7
  assign btn   = {btn_start, btn_down, btn_drop, btn_right, btn_left,
                  btn_rotate_rev, btn_rotate, btn_hold};
  // armed masks the first cycle after reset so a held button gives no edge
  assign press = btn & ~btn_prev & {8{armed}};

`ifdef TETRIS_CTRL_DAS_EN
  key_repeat #(.DAS(DAS_MS), .ARR(ARR_MS)) u_rep_left (
    .clk(clk), .reset(reset), .held(btn_left & ~btn_right & ~idle),
    .ms_tick(ms_tick), .tick(rpt_l)
  );
  key_repeat #(.DAS(DAS_MS), .ARR(ARR_MS)) u_rep_right (
    .clk(clk), .reset(reset), .held(btn_right & ~btn_left & ~idle),
    .ms_tick(ms_tick), .tick(rpt_r)
  );
  key_repeat #(.DAS(0), .ARR(ARR_MS)) u_rep_down (
    .clk(clk), .reset(reset), .held(btn_down & ~idle),
    .ms_tick(ms_tick), .tick(rpt_d)
  );
`else
  localparam int unsigned unused_rpt_ms = DAS_MS + ARR_MS;
  assign rpt_l = 1'b0;
  assign rpt_r = 1'b0;
  assign rpt_d = 1'b0;
`endif

  // Signed subtraction so high levels clamp to the floor instead of wrapping
  always_comb begin
    grav_raw    = int'(GRAV_BASE_MS) - int'(level) * int'(GRAV_STEP_MS);
    grav_period = (grav_raw < int'(GRAV_MIN_MS)) ? GRAV_MIN_MS : unsigned'(grav_raw);
  end

  assign grav_hit = ms_tick && !idle && !in_gen && ((grav_cnt + 32'd1) >= grav_period);

  always_ff @(posedge clk) begin
    if (reset || idle || in_gen) grav_cnt <= '0;
    else if (ms_tick)            grav_cnt <= grav_hit ? '0 : grav_cnt + 32'd1;
  end

  always_comb begin
    top_idx = '0;
    for (int i = NUM_CMD - 1; i >= 0; i--) begin
      if (pend[i]) top_idx = 3'(i);
    end
    issue = in_wait && (ctrl == NONE) && (pend != '0);

    clr_m = '0;
    if (issue) begin
      if (CMD_PRIO[top_idx] == DOWN) clr_m = DOWN_MASK;
      else                           clr_m[top_idx] = 1'b1;
    end

    set_m = {grav_hit, press[F_DOWN_USER] | rpt_d, press[F_DROP],
             press[F_RIGHT] | rpt_r, press[F_LEFT] | rpt_l, press[2:0]};

    // A set landing on the issue cycle survives the clear
    pend_nxt = (pend & ~clr_m) | set_m;
    if (in_gen) pend_nxt[F_DOWN_GRAV] = 1'b0;
    if (idle)   pend_nxt = '0;

    ctrl_nxt = NONE;
    if (press[7] && idle) ctrl_nxt = DOWN;
    else if (issue)       ctrl_nxt = CMD_PRIO[top_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= NONE;
      pend     <= '0;
      btn_prev <= '0;
      armed    <= 1'b0;
    end else begin
      ctrl     <= ctrl_nxt;
      pend     <= pend_nxt;
      btn_prev <= btn;
      armed    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || game_state == INIT)     points <= '0;
    else if (score_inc && points != '1)  points <= points + 16'd1;
  end

  assign lvl_div = 32'(points) / PTS_PER_LEVEL;
  assign level   = (lvl_div > 32'd15) ? 4'd15 : 4'(lvl_div);

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Bench for tetris_input_ctrl at 1 ms per cycle: directed scenarios with
// literal expectations plus randomized play against a behavioural model.
module tb_tetris_input_ctrl;
  import enum_type::*;

  localparam int unsigned CLK_HZ = 1000, DAS_MS = 170, ARR_MS = 50;
  localparam int unsigned GB = 1000, GS = 60, GM = 100, PPL = 16;
`ifdef TETRIS_CTRL_DAS_EN
  localparam bit DAS_EN = 1'b1;
`else
  localparam bit DAS_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic btn_left = 0, btn_right = 0, btn_rotate = 0, btn_rotate_rev = 0;
  logic btn_down = 0, btn_drop = 0, btn_hold = 0, btn_start = 0;
  logic score_inc = 0;
  state_type game_state = WAIT;
  state_type ctrl;
  logic [3:0] level;

  tetris_input_ctrl #(
    .CLK_HZ(CLK_HZ), .DAS_MS(DAS_MS), .ARR_MS(ARR_MS), .GRAV_BASE_MS(GB),
    .GRAV_STEP_MS(GS), .GRAV_MIN_MS(GM), .PTS_PER_LEVEL(PPL)
  ) dut (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .btn_rotate(btn_rotate), .btn_rotate_rev(btn_rotate_rev), .btn_down(btn_down),
    .btn_drop(btn_drop), .btn_hold(btn_hold), .btn_start(btn_start),
    .game_state(game_state), .score_inc(score_inc), .ctrl(ctrl), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  // ---------------- behavioural model ----------------
  bit [7:0]  m_prev = '0, m_pend = '0;
  bit        m_armed = 0;
  state_type m_ctrl = NONE;
  int        m_points = 0, m_grav = 0, m_dl = -1, m_dr = -1, m_dd = -1;

  function automatic int lvl_of(int pts);
    int l = pts / int'(PPL);
    return (l > 15) ? 15 : l;
  endfunction

  function automatic int period_of(int lv);
    int p = int'(GB) - lv * int'(GS);
    return (p < int'(GM)) ? int'(GM) : p;
  endfunction

  // d = ms held since the press cycle
  function automatic bit rep_due(int d, int first);
    return DAS_EN && d >= first && ((d - first) % int'(ARR_MS)) == 0;
  endfunction

  always @(posedge clk) begin
    bit [7:0] b, pr, setm, clrm;
    bit idle, gtick, tl, tr, td;
    int k;
    state_type nc;
    b = {btn_start, btn_down, btn_drop, btn_right, btn_left, btn_rotate_rev, btn_rotate, btn_hold};
    if (reset) begin
      m_prev = '0; m_pend = '0; m_armed = 0; m_ctrl = NONE;
      m_points = 0; m_grav = 0; m_dl = -1; m_dr = -1; m_dd = -1;
    end else begin
      idle = (game_state == INIT) || (game_state == END);
      pr = m_armed ? (b & ~m_prev) : 8'h00;
      nc = NONE; clrm = '0;
      if (pr[7] && idle) nc = DOWN;
      else if (game_state == WAIT && m_ctrl == NONE && m_pend != 0) begin
        k = 0;
        while (!m_pend[k]) k++;
        nc = CMD_PRIO[k];
        if (nc == DOWN) clrm = 8'hC0; else clrm[k] = 1'b1;
      end
      m_dl = (btn_left && !btn_right && !idle) ? m_dl + 1 : -1;
      m_dr = (btn_right && !btn_left && !idle) ? m_dr + 1 : -1;
      m_dd = (btn_down && !idle) ? m_dd + 1 : -1;
      tl = rep_due(m_dl, int'(DAS_MS));
      tr = rep_due(m_dr, int'(DAS_MS));
      td = rep_due(m_dd, int'(ARR_MS));
      gtick = 0;
      if (idle || game_state == GEN) m_grav = 0;
      else begin
        m_grav++;
        if (m_grav >= period_of(lvl_of(m_points))) begin gtick = 1; m_grav = 0; end
      end
      setm = {gtick, pr[6] | td, pr[5], pr[4] | tr, pr[3] | tl, pr[2:0]};
      m_pend = (m_pend & ~clrm) | setm;
      if (game_state == GEN) m_pend[7] = 0;
      if (idle) m_pend = '0;
      if (game_state == INIT) m_points = 0;
      else if (score_inc && m_points < 65535) m_points++;
      m_prev = b; m_armed = 1; m_ctrl = nc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (ctrl !== m_ctrl || level !== 4'(lvl_of(m_points))) begin
        errors++;
        $display("FAIL model_cmp t=%0t ctrl=%s level=%0d expected ctrl=%s level=%0d",
                 $time, ctrl.name(), level, m_ctrl.name(), lvl_of(m_points));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit core_auto = 1, rnd_core = 0;
  int busy = 0;
  state_type seen = NONE;

  // One clock plus a small core model: leaves WAIT the edge after a command
  task automatic cyc();
    @(posedge clk); #1;
    if (core_auto) begin
      case (game_state)
        WAIT: if (seen != NONE) begin game_state = LOCK; busy = 2; end
              else if (rnd_core && $urandom_range(0, 199) == 0) game_state = GEN;
              else if (rnd_core && $urandom_range(0, 599) == 0) game_state = END;
        LOCK: if (busy > 0) busy--;
              else game_state = (rnd_core && $urandom_range(0, 3) == 0) ? GEN : WAIT;
        GEN:  game_state = WAIT;
        END, INIT: if (rnd_core) begin
              if (seen == DOWN) game_state = GEN;
              else if ($urandom_range(0, 49) == 0) game_state = (game_state == END) ? INIT : END;
            end
        default: ;
      endcase
    end
    seen = ctrl;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic do_reset(input state_type g);
    reset = 1;
    {btn_left, btn_right, btn_rotate, btn_rotate_rev, btn_down, btn_drop, btn_hold, btn_start} = '0;
    score_inc = 0; game_state = g; busy = 0;
    cyc(); cyc();
    reset = 0;
    cyc();
    seen = NONE;
  endtask

  task automatic wait_cmd(input state_type c, input int limit, output int n);
    n = 0;
    do begin cyc(); n++; end while (ctrl != c && n < limit);
  endtask

  initial begin
    int n, cnt;
    int c1, c2;
    state_type seq[$];
    int times[$], exp_t[$];

    cyc();
    chk_en = 1;
    do_reset(WAIT);
    chk("reset_ctrl", int'(ctrl), int'(NONE));
    chk("reset_level", int'(level), 0);

    // tap left
    btn_left = 1; cyc(); btn_left = 0; c1 = int'(ctrl);
    cyc(); c2 = int'(ctrl);
    cnt = (ctrl == LEFT) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin cyc(); if (ctrl == LEFT) cnt++; end
    chk("tap_left_t1", c1, int'(NONE));
    chk("tap_left_t2", c2, int'(LEFT));
    chk("tap_left_count", cnt, 1);

    // simultaneous hold/rotate/drop
    do_reset(WAIT);
    btn_hold = 1; btn_rotate = 1; btn_drop = 1;
    cyc();
    btn_hold = 0; btn_rotate = 0; btn_drop = 0;
    for (int i = 0; i < 30; i++) begin cyc(); if (ctrl != NONE) seq.push_back(ctrl); end
    chk("prio_count", seq.size(), 3);
    if (seq.size() >= 3) begin
      chk("prio_0", int'(seq[0]), int'(HOLD));
      chk("prio_1", int'(seq[1]), int'(ROTATE));
      chk("prio_2", int'(seq[2]), int'(DROP));
    end

    // gravity restart by GEN at ms 5, then level-0 period
    do_reset(WAIT);
    repeat (4) cyc();
    game_state = GEN; cyc();
    wait_cmd(DOWN, 1200, n);
    chk("grav_gen_restart", n, 1001);
    wait_cmd(DOWN, 1200, n);
    chk("grav_period_l0", n, 1000);

    // level from score pulses
    do_reset(WAIT);
    score_inc = 1; repeat (32) cyc(); score_inc = 0; cyc();
    chk("level_32", int'(level), 2);
    game_state = GEN; cyc();
    wait_cmd(DOWN, 1200, n);
    chk("grav_period_l2", n, 881);
    score_inc = 1; repeat (368) cyc(); score_inc = 0; cyc();
    chk("level_400", int'(level), 15);
    game_state = GEN; cyc();
    wait_cmd(DOWN, 1200, n);
    chk("grav_period_l15", n, 101);

    // hold right 300 ms
    do_reset(WAIT);
    btn_right = 1;
    for (int i = 1; i <= 300; i++) begin cyc(); if (ctrl == RIGHT) times.push_back(i); end
    btn_right = 0;
    exp_t.push_back(2);
    if (DAS_EN) begin exp_t.push_back(172); exp_t.push_back(222); exp_t.push_back(272); end
    chk("rep_count", times.size(), exp_t.size());
    for (int i = 0; i < exp_t.size(); i++)
      chk($sformatf("rep_time_%0d", i), (i < times.size()) ? times[i] : -1, exp_t[i]);

    // start in END, then in WAIT
    do_reset(END);
    btn_start = 1; cyc(); c1 = int'(ctrl);
    cnt = (ctrl == DOWN) ? 1 : 0;
    for (int i = 0; i < 6; i++) begin cyc(); if (ctrl == DOWN) cnt++; end
    btn_start = 0;
    chk("start_end_t1", c1, int'(DOWN));
    chk("start_end_count", cnt, 1);
    do_reset(WAIT);
    btn_start = 1; cnt = 0;
    for (int i = 0; i < 8; i++) begin cyc(); if (ctrl != NONE) cnt++; end
    btn_start = 0;
    chk("start_wait_none", cnt, 0);

    // reset while LEFT pending, left still held across reset
    core_auto = 0;
    do_reset(LOCK);
    btn_left = 1; cyc(); cyc();
    reset = 1; cyc(); reset = 0;
    game_state = WAIT; cnt = 0;
    for (int i = 0; i < 10; i++) begin cyc(); if (ctrl != NONE) cnt++; end
    btn_left = 0;
    chk("reset_pending_left", cnt, 0);
    core_auto = 1;

    // randomized play against the model
    do_reset(WAIT);
    rnd_core = 1;
    for (int c = 0; c < 6000; c++) begin
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 119) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 119) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 119) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 15) == 0) btn_rotate = ~btn_rotate;
      if ($urandom_range(0, 15) == 0) btn_rotate_rev = ~btn_rotate_rev;
      if ($urandom_range(0, 23) == 0) btn_drop = ~btn_drop;
      if ($urandom_range(0, 23) == 0) btn_hold = ~btn_hold;
      if ($urandom_range(0, 15) == 0) btn_start = ~btn_start;
      score_inc = ($urandom_range(0, 39) == 0);
      cyc();
    end
    rnd_core = 0;
    do_reset(WAIT);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
